// File: rtl/dataflow_deadlock_monitor.sv
// Watches a wait-for graph between dataflow processes. Once the graph has held still
// long enough, it searches for a cycle and latches the first cycle it finds until cleared.
module dataflow_deadlock_monitor #(
  parameter int NUM_PROC      = 4,
  parameter int STABLE_CYCLES = 16,
  parameter logic [NUM_PROC*NUM_PROC-1:0] DEP_MASK = '1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_PROC-1:0]          blocked_vec,
  input  logic [NUM_PROC*NUM_PROC-1:0] wait_mat,
  input  logic                         clear,
  output logic                         dl_detect,
  output logic [$clog2(NUM_PROC)-1:0]  dl_origin,
  output logic [NUM_PROC-1:0]          dl_members,
  output logic                         busy
);
  localparam int NW = NUM_PROC * NUM_PROC;
  localparam int OW = $clog2(NUM_PROC);
  localparam logic [15:0]   CNT_LAST  = 16'(STABLE_CYCLES - 1);
  localparam logic [OW-1:0] ORIG_LAST = OW'(NUM_PROC - 1);
  localparam logic [OW-1:0] STEP_LAST = OW'(NUM_PROC - 2);

  typedef enum logic [1:0] {IDLE = 2'd0, WATCH = 2'd1, SEARCH = 2'd2, REPORT = 2'd3} state_t;

  state_t                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [OW-1:0]           orig_q, orig_d;
  logic [OW-1:0]           steps_q, steps_d;
  logic                    load_q, load_d;
  logic [NUM_PROC-1:0]     reach_q, reach_d;
  logic [NUM_PROC+NW-1:0]  snap_q, snap_d;
  logic                    det_q, det_d;
  logic [OW-1:0]           org_q, org_d;
  logic [NUM_PROC-1:0]     mem_q, mem_d;
  logic                    busy_q, busy_d;

  logic [NW-1:0]           edge_s;
  logic [NUM_PROC-1:0]     row_s, prop_s;
  logic                    change_s, skip_s, hit_s, done_s;

  // Legal, blocked-only, non-self wait edges; the snapshot is these plus blocked_vec.
  always_comb begin
    edge_s = wait_mat & DEP_MASK;
    for (int i = 0; i < NUM_PROC; i++) begin
      edge_s[i*NUM_PROC+i] = 1'b0;
      edge_s[i*NUM_PROC +: NUM_PROC] = blocked_vec[i] ? edge_s[i*NUM_PROC +: NUM_PROC]
                                                      : {NUM_PROC{1'b0}};
    end
    snap_d   = {blocked_vec, edge_s};
    change_s = (snap_d != snap_q);
  end

  // Row of the current origin and one step of reach-set expansion.
  always_comb begin
    row_s  = '0;
    prop_s = reach_q;
    for (int i = 0; i < NUM_PROC; i++) begin
      row_s  = row_s  | ((orig_q == OW'(i)) ? edge_s[i*NUM_PROC +: NUM_PROC] : {NUM_PROC{1'b0}});
      prop_s = prop_s | (reach_q[i] ? edge_s[i*NUM_PROC +: NUM_PROC] : {NUM_PROC{1'b0}});
    end
    skip_s = ~blocked_vec[orig_q];
    hit_s  = prop_s[orig_q];
    done_s = skip_s | (~load_q & ~hit_s & ((prop_s == reach_q) | (steps_q == STEP_LAST)));
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    orig_d  = orig_q;
    steps_d = steps_q;
    load_d  = load_q;
    reach_d = reach_q;
    det_d   = det_q;
    org_d   = org_q;
    mem_d   = mem_q;
    case (state_q)
      IDLE: begin
        if (|blocked_vec) begin
          state_d = WATCH;
          cnt_d   = 16'd0;
        end else begin
          state_d = IDLE;
        end
      end
      WATCH: begin
        if (blocked_vec == '0) begin
          state_d = IDLE;
        end else if (change_s) begin
          cnt_d = 16'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = SEARCH;
          orig_d  = '0;
          load_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SEARCH: begin
        if (change_s) begin
          state_d = WATCH;
          cnt_d   = 16'd0;
        end else if (done_s) begin
          // Origin exhausted: move on, or rearm the watch after the last one.
          if (orig_q == ORIG_LAST) begin
            state_d = WATCH;
            cnt_d   = 16'd0;
          end else begin
            orig_d = orig_q + OW'(1);
            load_d = 1'b1;
          end
        end else if (load_q) begin
          reach_d = row_s;
          steps_d = '0;
          load_d  = 1'b0;
        end else if (hit_s) begin
          state_d = REPORT;
          det_d   = 1'b1;
          org_d   = orig_q;
          mem_d   = prop_s | (NUM_PROC'(1) << orig_q);
        end else begin
          reach_d = prop_s;
          steps_d = steps_q + OW'(1);
        end
      end
      REPORT: begin
        if (clear) begin
          state_d = IDLE;
          det_d   = 1'b0;
          org_d   = '0;
          mem_d   = '0;
        end else begin
          state_d = REPORT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == WATCH) || (state_d == SEARCH);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      orig_q  <= '0;
      steps_q <= '0;
      load_q  <= 1'b0;
      reach_q <= '0;
      snap_q  <= '0;
      det_q   <= 1'b0;
      org_q   <= '0;
      mem_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      orig_q  <= orig_d;
      steps_q <= steps_d;
      load_q  <= load_d;
      reach_q <= reach_d;
      snap_q  <= snap_d;
      det_q   <= det_d;
      org_q   <= org_d;
      mem_q   <= mem_d;
      busy_q  <= busy_d;
    end
  end

  assign dl_detect  = det_q;
  assign dl_origin  = org_q;
  assign dl_members = mem_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_dataflow_deadlock_monitor.sv
// Bench for dataflow_deadlock_monitor: a 4-process full-mask instance and a 2-process
// instance with the 1->0 edge masked, both checked every cycle against a plan-based model.
module tb_dataflow_deadlock_monitor;
  localparam int ST = 4;

  logic        clock, reset, clear;
  logic [3:0]  a_blk;  logic [15:0] a_wm;
  logic        a_det;  logic [1:0]  a_org; logic [3:0] a_mem; logic a_busy;
  logic [1:0]  b_blk;  logic [3:0]  b_wm;
  logic        b_det;  logic [0:0]  b_org; logic [1:0] b_mem; logic b_busy;

  int n_tests = 0;
  int n_fail  = 0;

  dataflow_deadlock_monitor #(.NUM_PROC(4), .STABLE_CYCLES(ST)) dut_a (
    .clock(clock), .reset(reset), .blocked_vec(a_blk), .wait_mat(a_wm), .clear(clear),
    .dl_detect(a_det), .dl_origin(a_org), .dl_members(a_mem), .busy(a_busy));

  dataflow_deadlock_monitor #(.NUM_PROC(2), .STABLE_CYCLES(ST), .DEP_MASK(4'b1011)) dut_b (
    .clock(clock), .reset(reset), .blocked_vec(b_blk), .wait_mat(b_wm), .clear(clear),
    .dl_detect(b_det), .dl_origin(b_org), .dl_members(b_mem), .busy(b_busy));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model state per instance: 0 idle, 1 watch, 2 search, 3 report.
  int           np [2];
  logic [255:0] mk [2];
  int           m_st [2], m_cnt [2], m_left [2], m_org [2], p_org [2];
  bit           m_det [2], p_det [2];
  logic [15:0]  m_mem [2], p_mem [2], prev_blk [2];
  logic [15:0]  prev_e [2][16];
  logic [15:0]  cur_e [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_st[k] = 0; m_cnt[k] = 0; m_left[k] = 0; m_det[k] = 1'b0; m_org[k] = 0;
    m_mem[k] = 16'd0; prev_blk[k] = 16'd0;
    for (int i = 0; i < 16; i++) prev_e[k][i] = 16'd0;
  endtask

  // Whole search outcome and its length in cycles, for a snapshot held constant.
  task automatic make_plan(input int k, input logic [15:0] blk);
    int n = np[k];
    int cyc = 0;
    logic [15:0] r, nr;
    p_det[k] = 1'b0; p_org[k] = 0; p_mem[k] = 16'd0;
    for (int o = 0; o < n && !p_det[k]; o++) begin
      cyc++;
      if (!blk[o]) continue;
      r = cur_e[o];
      for (int s = 1; s < n; s++) begin
        cyc++;
        nr = r;
        for (int j = 0; j < n; j++) if (r[j]) nr = nr | cur_e[j];
        if (nr[o]) begin
          p_det[k] = 1'b1; p_org[k] = o; p_mem[k] = nr | (16'd1 << o);
          break;
        end
        if (nr == r) break;
        r = nr;
      end
    end
    m_left[k] = cyc;
  endtask

  task automatic model_step(input int k, input logic [15:0] blk, input logic [255:0] wm, input bit clr);
    int n = np[k];
    bit chg;
    for (int i = 0; i < n; i++) begin
      cur_e[i] = 16'd0;
      for (int j = 0; j < n; j++)
        if (i != j && blk[i] && wm[i*n+j] && mk[k][i*n+j]) cur_e[i][j] = 1'b1;
    end
    chg = (blk != prev_blk[k]);
    for (int i = 0; i < n; i++) if (cur_e[i] != prev_e[k][i]) chg = 1'b1;
    case (m_st[k])
      0: if (blk != 16'd0) begin m_st[k] = 1; m_cnt[k] = 0; end
      1: begin
        if (blk == 16'd0) m_st[k] = 0;
        else if (chg) m_cnt[k] = 0;
        else if (m_cnt[k] == ST - 1) begin m_st[k] = 2; make_plan(k, blk); end
        else m_cnt[k]++;
      end
      2: begin
        if (chg) begin m_st[k] = 1; m_cnt[k] = 0; end
        else begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            if (p_det[k]) begin
              m_st[k] = 3; m_det[k] = 1'b1; m_org[k] = p_org[k]; m_mem[k] = p_mem[k];
            end else begin
              m_st[k] = 1; m_cnt[k] = 0;
            end
          end
        end
      end
      default: if (clr) begin m_st[k] = 0; m_det[k] = 1'b0; m_org[k] = 0; m_mem[k] = 16'd0; end
    endcase
    prev_blk[k] = blk;
    for (int i = 0; i < 16; i++) prev_e[k][i] = (i < n) ? cur_e[i] : 16'd0;
  endtask

  task automatic compare_all();
    check("a_detect",  32'(a_det),  32'(m_det[0]));
    check("a_origin",  32'(a_org),  32'(m_org[0]));
    check("a_members", 32'(a_mem),  32'(m_mem[0]));
    check("a_busy",    32'(a_busy), 32'(m_st[0] == 1 || m_st[0] == 2));
    check("b_detect",  32'(b_det),  32'(m_det[1]));
    check("b_origin",  32'(b_org),  32'(m_org[1]));
    check("b_members", 32'(b_mem),  32'(m_mem[1]));
    check("b_busy",    32'(b_busy), 32'(m_st[1] == 1 || m_st[1] == 2));
  endtask

  task automatic cyc(input logic [3:0] ab, input logic [15:0] aw, input logic [1:0] bb,
                     input logic [3:0] bw, input bit clr);
    a_blk = ab; a_wm = aw; b_blk = bb; b_wm = bw; clear = clr;
    @(posedge clock);
    if (!reset) begin
      model_reset(0); model_reset(1);
    end else begin
      model_step(0, {12'd0, ab}, {240'd0, aw}, clr);
      model_step(1, {14'd0, bb}, {252'd0, bw}, clr);
    end
    #1;
    compare_all();
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_det"},  32'(a_det),  32'd0);
    check({nm, "_org"},  32'(a_org),  32'd0);
    check({nm, "_mem"},  32'(a_mem),  32'd0);
    check({nm, "_busy"}, 32'(a_busy), 32'd0);
  endtask

  initial begin
    bit found;
    np[0] = 4; np[1] = 2;
    mk[0] = 256'hFFFF; mk[1] = 256'hB;
    model_reset(0); model_reset(1);
    a_blk = 4'd0; a_wm = 16'd0; b_blk = 2'd0; b_wm = 4'd0; clear = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 check_zero("reset");
    repeat (3) cyc(4'd0, 16'd0, 2'd0, 4'd0, 1'b0);
    reset = 1'b1;

    // Two-process mutual wait: A reports origin 0; B has the 1->0 edge masked off.
    repeat (30) cyc(4'b0011, 16'h0012, 2'b11, 4'b0110, 1'b0);
    check("pair_det", 32'(a_det), 32'd1);
    check("pair_org", 32'(a_org), 32'd0);
    check("pair_mem", 32'(a_mem), 32'b0011);
    check("mask_det", 32'(b_det), 32'd0);

    // Report frozen while inputs drop, then cleared back to idle.
    repeat (10) cyc(4'd0, 16'd0, 2'd0, 4'd0, 1'b0);
    check("hold_det", 32'(a_det), 32'd1);
    check("hold_mem", 32'(a_mem), 32'b0011);
    cyc(4'd0, 16'd0, 2'd0, 4'd0, 1'b1);
    check_zero("clear");

    // Open chain 0->1->2->3 with 3 free: endless watch/search, never a report.
    for (int c = 0; c < 60; c++) cyc(4'b0111, 16'h0842, 2'd0, 4'd0, c == 20);
    check("chain_det",  32'(a_det),  32'd0);
    check("chain_busy", 32'(a_busy), 32'd1);

    // Cycle 1->2->3->1 with 0 hanging off it.
    repeat (60) cyc(4'b1111, 16'h2842, 2'd0, 4'd0, 1'b0);
    check("ring_det", 32'(a_det), 32'd1);
    check("ring_org", 32'(a_org), 32'd1);
    check("ring_mem", 32'(a_mem), 32'b1110);
    reset = 1'b0;
    #1 check_zero("rst_report");
    repeat (2) cyc(4'b1111, 16'h2842, 2'd0, 4'd0, 1'b0);
    reset = 1'b1;

    // Self-waits only.
    repeat (60) cyc(4'b1111, 16'h8421, 2'b11, 4'b1001, 1'b0);
    check("self_det", 32'(a_det), 32'd0);
    check("self_det_b", 32'(b_det), 32'd0);

    // Pair cycle with one edge toggling every 3 cycles never settles.
    for (int c = 0; c < 30; c++)
      cyc(4'b0011, ((c / 3) % 2 == 1) ? 16'h0010 : 16'h0012, 2'd0, 4'd0, 1'b0);
    check("toggle_det", 32'(a_det), 32'd0);

    // Reset while searching.
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      cyc(4'b0111, 16'h0842, 2'd0, 4'd0, 1'b0);
      if (m_st[0] == 2) found = 1'b1;
    end
    check("search_reached", {31'd0, found}, 32'd1);
    reset = 1'b0;
    #1 check_zero("rst_search");
    repeat (2) cyc(4'b0111, 16'h0842, 2'd0, 4'd0, 1'b0);
    reset = 1'b1;

    // Random held patterns with sparse waits and occasional clear pulses.
    for (int p = 0; p < 250; p++) begin
      logic [3:0]  ab;
      logic [15:0] aw;
      logic [1:0]  bb;
      logic [3:0]  bw;
      int len;
      ab  = 4'($urandom_range(0, 15));
      aw  = 16'($urandom & $urandom);
      if ($urandom_range(0, 1) == 1) aw = aw & 16'($urandom);
      bb  = 2'($urandom_range(0, 3));
      bw  = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 40);
      for (int c = 0; c < len; c++) cyc(ab, aw, bb, bw, $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dataflow_deadlock_monitor.md
DATAFLOW_DEADLOCK_MONITOR -- requirements
Module: dataflow_deadlock_monitor

Interface
REQ-001 SHALL have parameter NUM_PROC, default 4: number of monitored dataflow processes, range 2..16.
REQ-002 SHALL have parameter STABLE_CYCLES, default 16: cycles the wait-for snapshot must hold unchanged before a search starts, range 1..65535.
REQ-003 SHALL have parameter DEP_MASK, default all ones (NUM_PROC*NUM_PROC bits): bit i*NUM_PROC+j set means process i may legally wait on process j; bits i==j are ignored.
REQ-004 SHALL have port clock, input, 1: rising-edge clock.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port blocked_vec, input, NUM_PROC: bit i means process i is stalled on a FIFO handshake (blk_n low) or start FIFO.
REQ-007 SHALL have port wait_mat, input, NUM_PROC*NUM_PROC: bit i*NUM_PROC+j means process i currently waits on process j.
REQ-008 SHALL have port clear, input, 1: single-cycle pulse that releases a reported deadlock.
REQ-009 SHALL have port dl_detect, output, 1: sticky deadlock flag.
REQ-010 SHALL have port dl_origin, output, clog2(NUM_PROC): lowest-index process found in a cycle.
REQ-011 SHALL have port dl_members, output, NUM_PROC: reach set of dl_origin at detection.
REQ-012 SHALL have port busy, output, 1: high in states WATCH and SEARCH.

Function
REQ-013 SHALL form edge matrix E = wait_mat AND DEP_MASK, with diagonal forced to 0 and row i forced to 0 when blocked_vec[i]=0.
REQ-014 SHALL register snapshot S = {blocked_vec, E} every cycle; "change" means S differs from the previous cycle's S.
REQ-015 SHALL implement FSM states IDLE, WATCH, SEARCH, REPORT.
REQ-016 IDLE: SHALL go to WATCH when any bit of blocked_vec is set, loading stable counter to 0.
REQ-017 WATCH: SHALL increment the stable counter each unchanged cycle, reset it to 0 on change, return to IDLE when blocked_vec==0, and enter SEARCH with origin o=0 when counter==STABLE_CYCLES-1.
REQ-018 SEARCH: per origin o, the first cycle SHALL load reach=E row o; each following cycle SHALL set reach |= OR of E rows j for all j in reach.
REQ-019 SEARCH: SHALL detect when reach[o]=1, capture dl_origin=o and dl_members=reach|onehot(o) on that edge, and go to REPORT.
REQ-020 SEARCH: SHALL advance to o+1 without detection when reach is unchanged or after NUM_PROC-1 propagation cycles; after o=NUM_PROC-1 it SHALL return to WATCH with the counter at 0.
REQ-021 SEARCH: SHALL skip any origin with blocked_vec[o]=0 in one cycle.
REQ-022 SEARCH: a change of S SHALL abort the search to WATCH with counter 0 and no report.
REQ-023 Worst-case search latency SHALL be NUM_PROC*NUM_PROC cycles after WATCH exit.
REQ-024 REPORT: dl_detect, dl_origin and dl_members SHALL stay frozen regardless of inputs until clear=1; clear SHALL then zero all three next cycle and go to IDLE.
REQ-025 clear SHALL be ignored outside REPORT.
REQ-026 clear and a detection in the same cycle: detection SHALL win, and clear is lost.
REQ-027 A self-wait (i waits on i) SHALL never be reported.

Reset
REQ-028 On reset low, the FSM SHALL go to IDLE, and the counter, origin, reach, snapshot, dl_detect, dl_origin, dl_members and busy SHALL be 0, asynchronously.
REQ-029 Reset mid-SEARCH or mid-REPORT SHALL discard all state; there is no post-reset report.
REQ-030 After reset release, the first snapshot compare SHALL treat the previous S as 0.

Verification
REQ-031 NUM_PROC=2, STABLE_CYCLES=4, blocked=11, 0 waits on 1 and 1 waits on 0, held -> dl_detect=1 within 4+4 cycles, dl_origin=0, dl_members=11.
REQ-032 NUM_PROC=4, chain 0->1->2->3 with 3 idle and unblocked -> dl_detect stays 0 indefinitely and the FSM cycles WATCH/SEARCH with busy=1.
REQ-033 NUM_PROC=4, cycle 1->2->3->1 with 0 blocked on 1 -> dl_origin=1, dl_members=1110.
REQ-034 Two-process cycle where wait_mat toggles one bit every 3 cycles with STABLE_CYCLES=4 -> no SEARCH entry and dl_detect=0.
REQ-035 Report held while inputs go to 0, then a clear pulse -> outputs unchanged until clear, all 0 the next cycle, state IDLE.
REQ-036 DEP_MASK masking edge 1->0 in a 0<->1 cycle -> no detection; reset asserted mid-SEARCH -> all outputs 0 immediately.
